// File: rtl/uart_reg_file.sv
// Multi-register CDC write port: a synchronised four-phase req/ack handshake writes one of
// NUM_REGS registers; all registers are exported flat, with a registered random-access read port.
module uart_reg_file #(
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ack,
  output logic                       wr_strobe,
  output logic                       wr_err,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       dbg_state
);

  // Handshake: the source raises wr_req with wr_addr/wr_data stable and holds all three until it
  // sees wr_ack=1, then drops wr_req; wr_ack falls once the dropped request has been synchronised.
  // Exactly one register update (or one wr_err) happens per request.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [NUM_REGS-1:0]    wr_hit;
  logic [NUM_REGS-1:0]    rd_hit;
  logic                   wr_in_range;
  logic                   do_write;
  logic                   strobe_d;
  logic                   err_d;
  logic [DATA_W-1:0]      rd_next;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wr_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Address decode by explicit match so out-of-range addresses never index the array.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = (wr_addr == ADDR_W'(i));
      rd_hit[i] = (rd_addr == ADDR_W'(i));
    end
  end

  assign wr_in_range = |wr_hit;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit[i]) begin
        rd_next = rd_next | regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_s) begin
          next_state = S_ACK;
          if (wr_in_range) begin
            do_write = 1'b1;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (!req_s) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // rd_next is built from the pre-edge register values, so a same-edge write reads old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
      wr_strobe <= 1'b0;
      wr_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_write && wr_hit[i]) begin
          regs[i] <= wr_data;
        end
      end
      wr_strobe <= strobe_d;
      wr_err    <= err_d;
      rd_data   <= rd_next;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  assign wr_ack    = (state == S_ACK);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_reg_file.sv
// Bench for uart_reg_file: two instances (4 regs reset 5A, 3 regs reset 00) share one stimulus
// stream; a behavioural model is compared every cycle, plus hand-computed literal checks.
module tb_uart_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;

  logic        a_ack, a_stb, a_err, a_dbg;
  logic [7:0]  a_rd;
  logic [31:0] a_flat;
  logic        b_ack, b_stb, b_err, b_dbg;
  logic [7:0]  b_rd;
  logic [23:0] b_flat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_reg_file #(.DATA_W(8), .NUM_REGS(4), .SYNC_STAGES(2), .RESET_VAL(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(a_ack), .wr_strobe(a_stb), .wr_err(a_err), .rd_addr(rd_addr),
    .rd_data(a_rd), .regs_flat(a_flat), .dbg_state(a_dbg)
  );

  uart_reg_file #(.DATA_W(8), .NUM_REGS(3), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(b_ack), .wr_strobe(b_stb), .wr_err(b_err), .rd_addr(rd_addr),
    .rd_data(b_rd), .regs_flat(b_flat), .dbg_state(b_dbg)
  );

  // Model: the request is seen two edges late; each seen request yields one write (or error)
  // and an ack that lasts until the seen request drops.
  int         nreg [2] = '{4, 3};
  logic [7:0] rval [2] = '{8'h5A, 8'h00};
  logic [7:0] m_regs [2][4];
  logic       m_ack [2];
  logic       m_stb [2];
  logic       m_err [2];
  logic [7:0] m_rd  [2];
  logic       req_pipe [$];
  logic       m_live = 1'b0;

  always @(posedge clk) begin
    logic rs;
    if (rst) begin
      req_pipe = {};
      req_pipe.push_back(1'b0);
      req_pipe.push_back(1'b0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) m_regs[d][i] = rval[d];
        m_ack[d] = 1'b0;
        m_stb[d] = 1'b0;
        m_err[d] = 1'b0;
        m_rd[d]  = 8'h00;
      end
      m_live = 1'b1;
    end else begin
      rs = req_pipe.pop_front();
      req_pipe.push_back(wr_req);
      for (int d = 0; d < 2; d++) begin
        m_rd[d]  = (int'(rd_addr) < nreg[d]) ? m_regs[d][rd_addr] : 8'h00;
        m_stb[d] = 1'b0;
        m_err[d] = 1'b0;
        if (rs && !m_ack[d]) begin
          if (int'(wr_addr) < nreg[d]) begin
            m_regs[d][wr_addr] = wr_data;
            m_stb[d] = 1'b1;
          end else begin
            m_err[d] = 1'b1;
          end
          m_ack[d] = 1'b1;
        end else if (!rs && m_ack[d]) begin
          m_ack[d] = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] m_flat(int d);
    logic [31:0] f = '0;
    for (int i = 0; i < nreg[d]; i++) f[i*8 +: 8] = m_regs[d][i];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("a_ack",  32'(a_ack),  32'(m_ack[0]));
      check("a_stb",  32'(a_stb),  32'(m_stb[0]));
      check("a_err",  32'(a_err),  32'(m_err[0]));
      check("a_dbg",  32'(a_dbg),  32'(m_ack[0]));
      check("a_rd",   32'(a_rd),   32'(m_rd[0]));
      check("a_flat", a_flat,      m_flat(0));
      check("b_ack",  32'(b_ack),  32'(m_ack[1]));
      check("b_stb",  32'(b_stb),  32'(m_stb[1]));
      check("b_err",  32'(b_err),  32'(m_err[1]));
      check("b_dbg",  32'(b_dbg),  32'(m_ack[1]));
      check("b_rd",   32'(b_rd),   32'(m_rd[1]));
      check("b_flat", 32'(b_flat), m_flat(1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_write(input logic [1:0] addr, input logic [7:0] data);
    wr_addr = addr;
    wr_data = data;
    wr_req  = 1'b1;
  endtask

  initial begin
    int stb_cnt;
    rst = 1'b1; wr_req = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; rd_addr = 2'd0;
    tick(2);
    check("rst_a_flat", a_flat, 32'h5A5A5A5A);
    check("rst_b_flat", 32'(b_flat), 32'h00000000);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_a_rd", 32'(a_rd), 32'h00);
    rst = 1'b0;

    // Single write reg2 <= C3, lands on the third edge
    start_write(2'd2, 8'hC3);
    tick(2);
    check("wr_ack_early", 32'(a_ack), 32'd0);
    tick(1);
    check("wr_ack", 32'(a_ack), 32'd1);
    check("wr_stb", 32'(a_stb), 32'd1);
    check("wr_a_flat", a_flat, 32'h5AC35A5A);
    check("wr_b_flat", 32'(b_flat), 32'h00C30000);

    // Held request with changed data must not rewrite
    stb_cnt = int'(a_stb);
    wr_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      stb_cnt += int'(a_stb);
    end
    check("held_stb_cnt", 32'(stb_cnt), 32'd1);
    check("held_a_flat", a_flat, 32'h5AC35A5A);

    wr_req = 1'b0;
    tick(2);
    check("rel_ack_k1", 32'(a_ack), 32'd1);
    tick(1);
    check("rel_ack_k2", 32'(a_ack), 32'd0);

    // Addr 3: in range for dut_a, error for dut_b
    start_write(2'd3, 8'h11);
    tick(3);
    check("oor_b_err", 32'(b_err), 32'd1);
    check("oor_b_stb", 32'(b_stb), 32'd0);
    check("oor_b_ack", 32'(b_ack), 32'd1);
    check("oor_b_flat", 32'(b_flat), 32'h00C30000);
    check("oor_a_flat", a_flat, 32'h11C35A5A);
    tick(1);
    check("oor_b_err_pulse", 32'(b_err), 32'd0);
    wr_req = 1'b0;
    tick(3);
    check("oor_b_ack_rel", 32'(b_ack), 32'd0);
    rd_addr = 2'd3;
    tick(1);
    check("oor_b_rd", 32'(b_rd), 32'h00);
    check("oor_a_rd", 32'(a_rd), 32'h11);

    // Read/write collision on reg1
    rd_addr = 2'd1;
    start_write(2'd1, 8'h77);
    tick(3);
    check("col_b_rd_old", 32'(b_rd), 32'h00);
    check("col_a_rd_old", 32'(a_rd), 32'h5A);
    check("col_b_flat", 32'(b_flat), 32'h00C37700);
    tick(1);
    check("col_b_rd_new", 32'(b_rd), 32'h77);
    check("col_a_rd_new", 32'(a_rd), 32'h77);
    wr_req = 1'b0;
    tick(3);

    // Reset while acked with the request still high: write is replayed
    start_write(2'd0, 8'h3C);
    tick(3);
    check("mid_ack", 32'(a_ack), 32'd1);
    rst = 1'b1;
    tick(2);
    check("mid_rst_ack", 32'(a_ack), 32'd0);
    check("mid_rst_a_flat", a_flat, 32'h5A5A5A5A);
    check("mid_rst_b_flat", 32'(b_flat), 32'h00000000);
    check("mid_rst_rd", 32'(a_rd), 32'h00);
    rst = 1'b0;
    tick(2);
    check("replay_ack_early", 32'(a_ack), 32'd0);
    tick(1);
    check("replay_ack", 32'(a_ack), 32'd1);
    check("replay_stb", 32'(a_stb), 32'd1);
    check("replay_a_flat", a_flat, 32'h5A5A5A3C);
    check("replay_b_flat", 32'(b_flat), 32'h0000003C);
    wr_req = 1'b0;
    tick(4);
    check("final_ack", 32'(a_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
